// File: rtl/mem_access_unit.sv
// Load/store controller for a word-addressed memory with combinational read and synchronous write.
// Define SUBWORD_EN to enable byte/halfword loads and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int MEM_WORDS_BIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic [29:0] word_addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        accept;
  logic        size_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;

  assign accept = req_valid && (state_reg == IDLE);

`ifdef SUBWORD_EN
  assign size_bad = (req_size == 2'b11);
`else
  // Without sub-word support only word requests are legal.
  assign size_bad = (req_size != 2'b10);
`endif

  assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:MEM_WORDS_BIT+2];
  assign req_err      = size_bad || misaligned || out_of_range;

`ifdef SUBWORD_EN
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [1:0]  byte_off_reg;
  logic [31:0] rmw_word_reg;
  logic [31:0] shifted;
  logic [3:0]  lane_sel;
  logic [31:0] store_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_reg     <= 2'b00;
      signed_reg   <= 1'b0;
      byte_off_reg <= 2'b00;
      rmw_word_reg <= 32'd0;
    end else begin
      if (accept) begin
        size_reg     <= req_size;
        signed_reg   <= req_signed;
        byte_off_reg <= req_addr[1:0];
      end
      if (state_reg == RMW_RD) begin
        rmw_word_reg <= mem_rdata;
      end
    end
  end

  // Move the addressed lane down to bit 0, then extend.
  assign shifted = mem_rdata >> {byte_off_reg, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (size_reg)
      2'b00:   load_data = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sel[gi] = (size_reg == 2'b00) ? (byte_off_reg == 2'(gi))
                                                : (byte_off_reg[1] == 1'(gi / 2));
      assign store_word[8*gi +: 8] =
          !lane_sel[gi] ? rmw_word_reg[8*gi +: 8] :
          ((size_reg == 2'b01) && ((gi % 2) == 1)) ? wdata_reg[15:8] : wdata_reg[7:0];
    end
  endgenerate
`else
  logic unused_req_signed;
  assign unused_req_signed = req_signed;
  assign load_data         = mem_rdata;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (!req_write) begin
            state_next = RD;
          end else if (req_size == 2'b10) begin
            state_next = WR;
          end
`ifdef SUBWORD_EN
          else begin
            state_next = RMW_RD;
          end
`endif
        end
      end
      RD:      state_next = RESP;
      WR:      state_next = RESP;
`ifdef SUBWORD_EN
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      word_addr_reg <= 30'd0;
      wdata_reg     <= 32'd0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        word_addr_reg <= req_addr[31:2];
        wdata_reg     <= req_wdata;
        rsp_rdata_reg <= 32'd0;
        rsp_err_reg   <= req_err;
      end
      if (state_reg == RD) begin
        rsp_rdata_reg <= load_data;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // Memory strobes are decoded from state so reset removes them immediately.
  assign mem_read  = (state_reg == RD) || (state_reg == RMW_RD);
  assign mem_write = (state_reg == WR) || (state_reg == RMW_WR);
  assign mem_addr  = (mem_read || mem_write) ? {word_addr_reg, 2'b00} : 32'd0;

  always_comb begin
    mem_wdata = 32'd0;
    case (state_reg)
      WR:      mem_wdata = wdata_reg;
`ifdef SUBWORD_EN
      RMW_WR:  mem_wdata = store_word;
`endif
      default: mem_wdata = 32'd0;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the shared word-addressed instruction/data memory: combinational read, synchronous write, word granularity only.
- Accepts one load/store request at a time from the multi-cycle CPU datapath and drives the memory's address, write-data, read-enable and write-enable signals.
- Performs word-aligned accesses, byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores.
- Returns a single-cycle response pulse with data or an error flag.

Parameters:
- MEM_WORDS_BIT, 8: log2 of memory depth in words. Byte addresses at or above 2^(MEM_WORDS_BIT+2) are out of range.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal
- req_signed  input  1  load sign-extends when 1, zero-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load result; 0 for stores and errors
- rsp_err  output  1  request rejected; qualified by rsp_valid
- mem_addr  output  32  word-aligned byte address to memory
- mem_wdata  output  32  write data to memory
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset is asynchronous and active-high: reset is reset, clock is clk.
- Reset forces state IDLE and clears all captured registers. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- req_ready = (state==IDLE). A request is accepted at a rising edge with req_valid & req_ready. All req_* fields are captured at acceptance; later input changes are ignored.
- Error at acceptance, in priority order:
  - req_size==11
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0
  - out of range: addr[31:MEM_WORDS_BIT+2]!=0
  - Error goes straight to RESP with rsp_err=1 and rsp_rdata=0. No mem_read or mem_write is ever asserted for an erroneous request.
- Transitions from IDLE:
  - load → RD
  - word store → WR
  - byte/halfword store → RMW_RD
- Access states:
  - RD: mem_read=1, mem_addr={addr[31:2],2'b00}. At the edge, extract and extend from mem_rdata into rsp_rdata, then → RESP.
  - WR: mem_write=1, mem_wdata=req_wdata → RESP.
  - RMW_RD: mem_read=1. Capture mem_rdata → RMW_WR.
  - RMW_WR: mem_write=1, mem_wdata = captured word with the target lane replaced → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. rsp_rdata and rsp_err are held stable until the next acceptance.
- mem_read, mem_write and mem_addr are combinational from state and captured registers. mem_read and mem_write are 0 outside their states. mem_addr=0 in IDLE and RESP. mem_read and mem_write are never both 1.
- Lane map is little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k]
  - halfword h=addr[1] occupies bits [16h+15:16h]
  - stores use req_wdata[7:0] or req_wdata[15:0]
- Latency from acceptance edge T to rsp_valid high:
  - error: cycle T+1
  - load or word store: cycle T+2
  - sub-word store: cycle T+3
- Back-to-back: a new request can be accepted on the edge that ends RESP is not allowed; acceptance occurs only from IDLE. Minimum spacing is therefore response+1 cycle.
- Reset mid-operation: the unit aborts immediately to IDLE and mem_write drops asynchronously.
  - No response is produced.
  - A write not yet clocked is lost.
  - An RMW interrupted between RMW_RD and RMW_WR leaves memory unchanged.

Optional Feature:
- Macro: SUBWORD_EN.
- Defined: byte/halfword loads and stores as above.
- Undefined: req_size 00 and 01 are treated as errors (rsp_err=1, no memory access). RMW_RD and RMW_WR and the extraction logic are not built. Only word accesses proceed.

Test Plan:
- Word store 0x12345678 to 0x100, then word load from 0x100 → mem_write pulse one cycle at mem_addr 0x100. Load rsp_rdata=0x12345678 with rsp_valid at T+2.
- Memory word 0x80FF7F01 at 0x104. Signed byte load from 0x107 → 0xFFFFFF80. Unsigned → 0x00000080. Signed half from 0x104 → 0x00007F01. Signed half from 0x106 → 0xFFFF80FF.
- Memory 0xAABBCCDD at 0x108. Byte store 0x11 to 0x109 → RMW_RD then RMW_WR. Memory becomes 0xAABB11DD. rsp_valid at T+3.
- Half load from 0x10B, word store to 0x102, size=11, and load from 0x400 (MEM_WORDS_BIT=8) → each gives rsp_err=1 at T+1. mem_read and mem_write stay 0 throughout.
- Assert reset during RMW_WR of a byte store to 0x10C (memory 0) → mem_write drops the same cycle. No rsp_valid. Memory at 0x10C stays 0. req_ready=1 after reset releases.
- SUBWORD_EN undefined: byte load from 0x100 → rsp_err=1 at T+1, no memory access. Word load from 0x100 still returns the stored value.
